// File: rtl/tbird_signal_controller.sv
// tbird_signal_controller
// Single arbitrated sequencer for the T-Bird rear lamp clusters (3 lamps/side).
// Owns the slow-tick divider, latches a mode at each IDLE tick sample, steps
// P1 -> P2 -> P3 -> IDLE one step per tick, and overlays brake on any side
// that is not sequencing.
// Optional feature macro: TBIRD_HAZARD_EN (hazard / left+right -> mode 11).
module tbird_signal_controller #(
    parameter int TICK_DIV = 100_000_000,
    parameter int CNT_W    = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_req,
    input  logic       right_req,
    input  logic       hazard_req,
    input  logic       brake,
    output logic [2:0] left_lights,
    output logic [2:0] right_lights,
    output logic [1:0] mode,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, P1, P2, P3} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             tick;
    state_t           state_reg, state_next;
    logic [1:0]       mode_reg, mode_next;
    logic [1:0]       req_mode;
    logic [2:0]       seq_pattern;
    logic [2:0]       brake_pattern;
    logic [1:0]       side_seq;
    logic [2:0]       side_next [2];
    logic [2:0]       left_reg, right_reg;

    // Free-running step divider; requests never restart it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == CNT_LAST);

    // Request arbitration into a 2-bit mode code.
`ifdef TBIRD_HAZARD_EN
    always_comb begin
        req_mode = 2'b00;
        if (hazard_req || (left_req && right_req)) begin
            req_mode = 2'b11;
        end else if (left_req) begin
            req_mode = 2'b01;
        end else if (right_req) begin
            req_mode = 2'b10;
        end
    end
`else
    // Hazard input is ignored in this build; keep it tied off.
    logic hazard_unused;
    assign hazard_unused = hazard_req;

    always_comb begin
        req_mode = 2'b00;
        if (left_req && right_req) begin
            req_mode = 2'b00;
        end else if (left_req) begin
            req_mode = 2'b01;
        end else if (right_req) begin
            req_mode = 2'b10;
        end
    end
`endif

    // State and latched-mode registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            mode_reg  <= 2'b00;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
        end
    end

    // Next-state: advance only on tick; mode is sampled in IDLE and cleared
    // when the sequence finishes so an idle controller always shows brake.
    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        if (tick) begin
            case (state_reg)
                IDLE: begin
                    mode_next  = req_mode;
                    state_next = (req_mode != 2'b00) ? P1 : IDLE;
                end
                P1:      state_next = P2;
                P2:      state_next = P3;
                P3: begin
                    state_next = IDLE;
                    mode_next  = 2'b00;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Sequencing-side pattern for the upcoming state.
    always_comb begin
        seq_pattern = 3'b000;
        case (state_next)
            P1:      seq_pattern = 3'b001;
            P2:      seq_pattern = 3'b011;
            P3:      seq_pattern = 3'b111;
            default: seq_pattern = 3'b000;
        endcase
    end

    assign brake_pattern = {3{brake}};

    // Mode bit 0 selects left sequencing, bit 1 right; in hazard both
    // sequence, which also suppresses the brake overlay.
    assign side_seq = mode_next;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_side
            assign side_next[gi] = side_seq[gi] ? seq_pattern : brake_pattern;
        end
    endgenerate

    // Lamp output registers, loaded from next-cycle state/mode/brake.
    always_ff @(posedge clk) begin
        if (reset) begin
            left_reg  <= 3'b000;
            right_reg <= 3'b000;
        end else begin
            left_reg  <= side_next[0];
            right_reg <= side_next[1];
        end
    end

    assign left_lights  = left_reg;
    assign right_lights = right_reg;
    assign mode         = mode_reg;
    assign busy         = (state_reg != IDLE);

endmodule
